// File: rtl/sequence_enumerator.sv
// Enumerates every gate sequence of length 1..min(max_length, DEPTH_MAX) in odometer order,
// one index/gate beat per ready/available transfer. Optional macro PRUNE_REPEAT_EN skips
// sequences containing two equal adjacent gates.
module sequence_enumerator #(
  parameter int unsigned NUM_GATES = 24,
  parameter int unsigned GATE_W    = 5,
  parameter int unsigned DEPTH_MAX = 16,
  parameter int unsigned IDX_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  max_length,
  input  logic              start,
  input  logic              abort,
  output logic              complete,
  output logic [IDX_W-1:0]  seq_index,
  output logic [GATE_W-1:0] seq_gate,
  output logic              ready,
  output logic              first,
  output logic              last,
  input  logic              available
);

  // Gate storage spans the full index space so idx_q addresses it without truncation.
  localparam int unsigned       Slots   = 2 ** IDX_W;
  localparam logic [GATE_W-1:0] TopGate = GATE_W'(NUM_GATES - 1);

  typedef enum logic [1:0] {StIdle, StEmit, StAdvance, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   lim_q, lim_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   eff_lim;
  logic [GATE_W-1:0]  gates_q [Slots];
  logic [GATE_W-1:0]  gates_d [Slots];
  logic [GATE_W-1:0]  inc_gates [Slots];
  logic               inc_carry;
`ifdef PRUNE_REPEAT_EN
  logic               inc_legal;
`endif

  assign eff_lim = (max_length > IDX_W'(DEPTH_MAX)) ? IDX_W'(DEPTH_MAX) : max_length;

  // Next odometer value over the active length; index len_q-1 is the least significant digit.
  always_comb begin
    inc_gates = gates_q;
    inc_carry = 1'b1;
    for (int i = int'(DEPTH_MAX) - 1; i >= 0; i--) begin
      if ((IDX_W'(i) < len_q) && inc_carry) begin
        if (gates_q[IDX_W'(i)] == TopGate) begin
          inc_gates[IDX_W'(i)] = '0;
        end else begin
          inc_gates[IDX_W'(i)] = gates_q[IDX_W'(i)] + GATE_W'(1);
          inc_carry            = 1'b0;
        end
      end
    end
`ifdef PRUNE_REPEAT_EN
    inc_legal = 1'b1;
    for (int i = 1; i < int'(DEPTH_MAX); i++) begin
      if ((IDX_W'(i) < len_q) && (inc_gates[IDX_W'(i)] == inc_gates[IDX_W'(i - 1)])) begin
        inc_legal = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lim_d   = lim_q;
    idx_d   = idx_q;
    gates_d = gates_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lim_d   = eff_lim;
          len_d   = IDX_W'(1);
          idx_d   = '0;
          gates_d = '{default: '0};
          state_d = (eff_lim == '0) ? StDone : StEmit;
        end
      end
      StEmit: begin
        if (abort) begin
          idx_d   = '0;
          state_d = StDone;
        end else if (available) begin
          if (idx_q == len_q - IDX_W'(1)) begin
            idx_d   = '0;
            state_d = StAdvance;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StAdvance: begin
        if (abort) begin
          state_d = StDone;
        end else if (inc_carry) begin
          if (len_q == lim_q) begin
            state_d = StDone;
          end else begin
            len_d   = len_q + IDX_W'(1);
            state_d = StEmit;
`ifdef PRUNE_REPEAT_EN
            // 0,1,0,1,... is the smallest repeat-free sequence of any length.
            for (int i = 0; i < int'(DEPTH_MAX); i++) begin
              gates_d[IDX_W'(i)] = GATE_W'(i % 2);
            end
`else
            gates_d = '{default: '0};
`endif
          end
        end else begin
          gates_d = inc_gates;
`ifdef PRUNE_REPEAT_EN
          state_d = inc_legal ? StEmit : StAdvance;
`else
          state_d = StEmit;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= IDX_W'(1);
      lim_q   <= '0;
      idx_q   <= '0;
      gates_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lim_q   <= lim_d;
      idx_q   <= idx_d;
      gates_q <= gates_d;
    end
  end

  always_comb begin
    ready     = (state_q == StEmit);
    complete  = (state_q == StDone);
    first     = ready && (idx_q == '0);
    last      = ready && (idx_q == len_q - IDX_W'(1));
    seq_index = idx_q;
    seq_gate  = gates_q[idx_q];
  end

endmodule
